// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C burst target: FSM state encoding,
// ACK/NACK line levels and pointer byte-count sizing.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEVADDR = 4'd1,
    DEVACK  = 4'd2,
    PTR     = 4'd3,
    PTRACK  = 4'd4,
    WDATA   = 4'd5,
    WDACK   = 4'd6,
    RDATA   = 4'd7,
    RDACK   = 4'd8,
    IGNORE  = 4'd9
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Number of pointer bytes needed to cover a memory address of width w.
  function automatic int unsigned PTR_BYTES(input int unsigned w);
    return (w + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-FF synchroniser, FILT_LEN-sample level filter and
// registered one-cycle scl_rise/scl_fall/START/STOP pulses.
module i2c_line_cond #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [1:0]          scl_sync_q, sda_sync_q;
  logic [FILT_LEN-1:0] scl_hist_q, sda_hist_q;
  logic                scl_f_q, sda_f_q, scl_f_d, sda_f_d;
  logic                scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;

  // A level is only accepted once the whole history window agrees.
  always_comb begin
    scl_f_d = scl_f_q;
    sda_f_d = sda_f_q;
    if (&scl_hist_q)       scl_f_d = 1'b1;
    else if (~|scl_hist_q) scl_f_d = 1'b0;
    if (&sda_hist_q)       sda_f_d = 1'b1;
    else if (~|sda_hist_q) sda_f_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= FILT_LEN'({scl_hist_q, scl_sync_q[1]});
      sda_hist_q <= FILT_LEN'({sda_hist_q, sda_sync_q[1]});
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_rise_q <= scl_f_d & ~scl_f_q;
      scl_fall_q <= ~scl_f_d & scl_f_q;
      start_q    <= scl_f_q & scl_f_d & sda_f_q & ~sda_f_d;
      stop_q     <= scl_f_q & scl_f_d & ~sda_f_q & sda_f_d;
      sda_q      <= sda_f_d;
    end
  end

  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign sda_o      = sda_q;

endmodule

// File: rtl/i2c_burst_target.sv
// I2C target with multi-byte register pointer and auto-incrementing burst
// reads/writes onto a simple ce/rden/wren memory bus; SCL/SDA are oversampled.
module i2c_burst_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h01,
  parameter int unsigned MEM_ADDR_W = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  mem_ce,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NPTR      = PTR_BYTES(MEM_ADDR_W);
  localparam int unsigned PTR_CNT_W = $clog2(NPTR + 1);

  if (DATA_W != 8) begin : g_bad_data_w
    $error("i2c_burst_target: DATA_W must be 8");
  end

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_line_cond (
    .clk_i      (clk),
    .reset_i    (reset),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop),
    .sda_o      (sda_s)
  );

  i2c_state_t            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  byte_full_q, byte_full_d;
  logic [BYTE_W-1:0]     shift_q, shift_d;
  logic [MEM_ADDR_W-1:0] ptr_q, ptr_d;
  logic [PTR_CNT_W-1:0]  ptr_cnt_q, ptr_cnt_d;
  logic                  rw_q, rw_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  ce_q, ce_d, rden_q, rden_d, wren_q, wren_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  rd_cap_q, rd_cap_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_full_q <= 1'b0;
      shift_q     <= '0;
      ptr_q       <= '0;
      ptr_cnt_q   <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      ce_q        <= 1'b0;
      rden_q      <= 1'b0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      rd_cap_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_full_q <= byte_full_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      ptr_cnt_q   <= ptr_cnt_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      ce_q        <= ce_d;
      rden_q      <= rden_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      rd_cap_q    <= rd_cap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_full_d = byte_full_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    ptr_cnt_d   = ptr_cnt_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    ce_d        = 1'b0;
    rden_d      = 1'b0;
    wren_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    rd_cap_d    = rden_q;

    // Read data is valid the clk after the strobe; capture it one clk later.
    if (rd_cap_q) shift_d = BYTE_W'(mem_rdata);

    if (start) begin
      state_d     = DEVADDR;
      bit_cnt_d   = '0;
      byte_full_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
    end else if (stop) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      byte_full_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        DEVADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[BYTE_W-2:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_full_d = 1'b1;
          end else if (scl_fall && byte_full_q) begin
            byte_full_d = 1'b0;
            if (state_q == DEVADDR) begin
              if (shift_q[7:1] == DEV_ADDR && shift_q[7:1] != 7'd0) begin
                state_d  = DEVACK;
                sda_oe_d = ~I2C_ACK;
                rw_d     = shift_q[0];
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end else if (state_q == PTR) begin
              state_d   = PTRACK;
              sda_oe_d  = ~I2C_ACK;
              ptr_d     = MEM_ADDR_W'({ptr_q, shift_q});
              ptr_cnt_d = ptr_cnt_q + PTR_CNT_W'(1);
            end else begin
              state_d  = WDACK;
              sda_oe_d = ~I2C_ACK;
              ce_d     = 1'b1;
              wren_d   = 1'b1;
              addr_d   = ptr_q;
              wdata_d  = DATA_W'(shift_q);
            end
          end
        end
        DEVACK: begin
          // Reads fetch at the ACK-bit rise so bit 7 is ready for the next fall.
          if (scl_rise && rw_q) begin
            state_d   = RDATA;
            bit_cnt_d = '0;
            ce_d      = 1'b1;
            rden_d    = 1'b1;
            addr_d    = ptr_q;
          end else if (scl_fall) begin
            state_d   = PTR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            ptr_cnt_d = '0;
          end
        end
        PTRACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = (ptr_cnt_q == PTR_CNT_W'(NPTR)) ? WDATA : PTR;
          end
        end
        WDACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + MEM_ADDR_W'(1);
            state_d  = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_full_d = 1'b1;
          end else if (scl_fall) begin
            if (byte_full_q) begin
              byte_full_d = 1'b0;
              state_d     = RDACK;
              sda_oe_d    = 1'b0;
              ptr_d       = ptr_q + MEM_ADDR_W'(1);
            end else begin
              sda_oe_d = ~shift_q[BYTE_W-1];
              shift_d  = {shift_q[BYTE_W-2:0], 1'b1};
            end
          end
        end
        RDACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              state_d   = RDATA;
              bit_cnt_d = '0;
              ce_d      = 1'b1;
              rden_d    = 1'b1;
              addr_d    = ptr_q;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign mem_ce    = ce_q;
  assign mem_rden  = rden_q;
  assign mem_wren  = wren_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule
